// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-add slice (two half-adder cells and an OR)
// is sequenced LSB-first by an IDLE/ADD/DONE FSM with a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-2:0] shift_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             a_bit, b_bit;
    logic             ha0_s, ha0_c, ha1_s, ha1_c;
    logic             sum_bit, carry_next;
    logic             last_bit;
    logic [WIDTH-1:0] shift_next;

    assign a_bit = a_reg[cnt_reg];
    assign b_bit = b_reg[cnt_reg];

    // Full add built from two half-adder cells plus an OR on their carries.
    assign ha0_s      = a_bit ^ b_bit;
    assign ha0_c      = a_bit & b_bit;
    assign ha1_s      = ha0_s ^ carry_reg;
    assign ha1_c      = ha0_s & carry_reg;
    assign sum_bit    = ha1_s;
    assign carry_next = ha0_c | ha1_c;

    assign last_bit   = (cnt_reg == CNT_W'(WIDTH - 1));
    // Only WIDTH-1 partial bits are stored; the newest bit completes the word.
    assign shift_next = {sum_bit, shift_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            shift_reg <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= 1'b0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= ADD;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                ADD: begin
                    shift_reg <= shift_next[WIDTH-1:1];
                    carry_reg <= carry_next;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (last_bit) begin
                        sum       <= shift_next;
                        cout      <= carry_next;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised and directed check of serial_adder_ctrl at WIDTH=8 and WIDTH=2
// against plain a+b arithmetic and the start/busy/done timing rules.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, start2 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy8, done8, cout8, busy2, done2, cout2;
    logic [7:0] sum8;
    logic [1:0] sum2;

    int check_cnt = 0;
    int pass_cnt  = 0;
    logic [32:0] last_res [2];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            pass_cnt++;
    endtask

    task automatic drive(input int w, input logic st, input logic [31:0] av, input logic [31:0] bv);
        if (w == 8) begin
            start8 = st; a8 = av[7:0]; b8 = bv[7:0];
        end else begin
            start2 = st; a2 = av[1:0]; b2 = bv[1:0];
        end
    endtask

    task automatic sample(input int w, output logic bz, output logic dn, output logic [32:0] res);
        if (w == 8) begin
            bz = busy8; dn = done8; res = {24'd0, cout8, sum8};
        end else begin
            bz = busy2; dn = done2; res = {30'd0, cout2, sum2};
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete operation with a one-cycle start pulse; checks latency, busy
    // length, result hold during ADD, the result and the single-cycle done.
    task automatic add_op(input int w, input logic [31:0] av, input logic [31:0] bv, input string tag);
        logic [63:0] total;
        logic [32:0] exp_res, res;
        logic bz, dn, held;
        int lat, busy_cnt, idx;
        idx = (w == 8) ? 0 : 1;
        total = 64'(av) + 64'(bv);
        exp_res = total[32:0];
        drive(w, 1'b1, av, bv);
        tick();
        drive(w, 1'b0, $urandom, $urandom);
        lat = 0; busy_cnt = 0; held = 1'b1;
        sample(w, bz, dn, res);
        while (!dn && lat < w + 4) begin
            if (bz) busy_cnt++;
            if (res !== last_res[idx]) held = 1'b0;
            tick();
            lat++;
            sample(w, bz, dn, res);
        end
        check({tag, "_latency"}, 64'(lat), 64'(w));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(w));
        check({tag, "_done"}, 64'(dn), 64'd1);
        check({tag, "_busy_at_done"}, 64'(bz), 64'd0);
        check({tag, "_hold_during_add"}, 64'(held), 64'd1);
        check({tag, "_result"}, 64'(res), 64'(exp_res));
        last_res[idx] = exp_res;
        tick();
        sample(w, bz, dn, res);
        check({tag, "_done_drop"}, 64'(dn), 64'd0);
        check({tag, "_result_stable"}, 64'(res), 64'(exp_res));
    endtask

    initial begin : main
        logic bz, dn;
        logic [32:0] res;
        int dcnt, lat;

        last_res[0] = '0;
        last_res[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        sample(8, bz, dn, res);
        check("reset_busy", 64'(bz), 64'd0);
        check("reset_done", 64'(dn), 64'd0);
        check("reset_result", 64'(res), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        add_op(8, 32'h0F, 32'h01, "add_0f_01");
        add_op(8, 32'hFF, 32'h01, "add_ff_01");
        add_op(8, 32'hA5, 32'h5A, "add_a5_5a");

        // start pulsed during ADD must be ignored
        drive(8, 1'b1, 32'h11, 32'h22);
        tick();
        drive(8, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        drive(8, 1'b1, 32'hFF, 32'hFF);
        tick();
        drive(8, 1'b0, 32'h0, 32'h0);
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            sample(8, bz, dn, res);
            if (dn) dcnt++;
            tick();
        end
        sample(8, bz, dn, res);
        check("ignore_done_count", 64'(dcnt), 64'd1);
        check("ignore_result", 64'(res), 64'h33);
        last_res[0] = 33'h33;

        // start held high through DONE: back-to-back second operation
        drive(8, 1'b1, 32'h01, 32'h02);
        tick();
        lat = 0;
        sample(8, bz, dn, res);
        while (!dn && lat < 12) begin
            tick();
            lat++;
            sample(8, bz, dn, res);
        end
        check("b2b_first_latency", 64'(lat), 64'd8);
        check("b2b_first_result", 64'(res), 64'h003);
        drive(8, 1'b1, 32'h80, 32'h80);
        tick();
        sample(8, bz, dn, res);
        check("b2b_rebusy", 64'(bz), 64'd1);
        check("b2b_done_low", 64'(dn), 64'd0);
        drive(8, 1'b0, 32'h0, 32'h0);
        lat = 0;
        while (!dn && lat < 12) begin
            tick();
            lat++;
            sample(8, bz, dn, res);
        end
        check("b2b_second_latency", 64'(lat), 64'd8);
        check("b2b_second_result", 64'(res), 64'h100);
        last_res[0] = 33'h100;
        tick();

        // asynchronous reset in the 4th ADD cycle
        drive(8, 1'b1, 32'h12, 32'h34);
        tick();
        drive(8, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        sample(8, bz, dn, res);
        check("async_rst_busy", 64'(bz), 64'd0);
        check("async_rst_done", 64'(dn), 64'd0);
        check("async_rst_result", 64'(res), 64'd0);
        last_res[0] = '0;
        last_res[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        add_op(8, 32'h03, 32'h04, "after_rst_03_04");

        for (int i = 0; i < 1000; i++)
            add_op(8, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), "rand_w8");
        for (int i = 0; i < 1000; i++)
            add_op(2, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), "rand_w2");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
